// File: rtl/pwrbtn_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pwrbtn_seq_pkg
// Purpose  : Shared types and constants for the power-button sequencer:
//            sequencer state enumeration, grant encoding and the width of
//            the millisecond counter.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package pwrbtn_seq_pkg;

    localparam int MS_CNT_W = 13;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_PRESS    = 3'd1,
        ST_WAIT_S3  = 3'd2,
        ST_OVERRIDE = 3'd3,
        ST_COOLDOWN = 3'd4
    } seq_state_t;

    localparam logic [1:0] GRANT_NONE  = 2'd0;
    localparam logic [1:0] GRANT_FAULT = 2'd1;
    localparam logic [1:0] GRANT_BMC   = 2'd2;
    localparam logic [1:0] GRANT_FP    = 2'd3;

    // Counter value seen in the cycle of the final tick of an ms interval:
    // the interval ends when that tick arrives, so the compare is against
    // ms-1 qualified with the tick.
    function automatic logic [MS_CNT_W-1:0] last_tick(input int ms);
        return MS_CNT_W'(ms - 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/pwrbtn_seq_ctrl_ms_timer.sv
`default_nettype none
// ============================================================================
// Module   : ms_timer
// Purpose  : Millisecond tick counter. Clears synchronously, counts one per
//            tick and saturates at all-ones.
// Ports    : clk   - clock
//            rst_n - synchronous active-low reset
//            clear - zero the count (wins over tick)
//            tick  - one-cycle 1 ms strobe
//            count - ticks seen since the last clear
// Revision : 1.0 - initial release
// ============================================================================
module ms_timer
    import pwrbtn_seq_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clear,
    input  logic                tick,
    output logic [MS_CNT_W-1:0] count
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (tick && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/pwrbtn_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pwrbtn_seq_ctrl
// Purpose  : Arbitrates power-button requests from a fault input, the BMC and
//            the front panel, and drives the PCH power button with a timed
//            press, a forced-off override hold, a wait for SLP_S3 and a
//            cooldown lockout.
// Ports    : iClk_2M              - 2 MHz clock
//            iRst_n               - synchronous active-low reset
//            i1mSCE               - one-cycle 1 ms tick
//            iFpPwrBtn_n          - debounced front-panel button, low=pressed
//            iBmcPwrBtn_n         - BMC button request, low=pressed
//            FM_BMC_ONCTL_N_LATCH - latched BMC ON control, low=on requested
//            FM_SLPS3_N/4_N       - PCH sleep states
//            iForceOff            - level fault request for forced off
//            oPchPwrBtn_n         - registered button to PCH, low=pressed
//            oGrant               - owner: 0 none, 1 fault, 2 BMC, 3 panel
//            oBusy                - high outside IDLE
//            oTimeout             - sticky SLP_S3 wait timeout
// Revision : 1.0 - initial release
// ============================================================================
module pwrbtn_seq_ctrl
    import pwrbtn_seq_pkg::*;
#(
    parameter int PULSE_MS    = 200,
    parameter int OVERRIDE_MS = 4000,
    parameter int TIMEOUT_MS  = 1000,
    parameter int COOLDOWN_MS = 100
) (
    input  logic       iClk_2M,
    input  logic       iRst_n,
    input  logic       i1mSCE,
    input  logic       iFpPwrBtn_n,
    input  logic       iBmcPwrBtn_n,
    input  logic       FM_BMC_ONCTL_N_LATCH,
    input  logic       FM_SLPS3_N,
    input  logic       FM_SLPS4_N,
    input  logic       iForceOff,
    output logic       oPchPwrBtn_n,
    output logic [1:0] oGrant,
    output logic       oBusy,
    output logic       oTimeout
);

    localparam logic [MS_CNT_W-1:0] PULSE_LAST    = last_tick(PULSE_MS);
    localparam logic [MS_CNT_W-1:0] OVERRIDE_LAST = last_tick(OVERRIDE_MS);
    localparam logic [MS_CNT_W-1:0] TIMEOUT_LAST  = last_tick(TIMEOUT_MS);
    localparam logic [MS_CNT_W-1:0] COOLDOWN_LAST = last_tick(COOLDOWN_MS);

    seq_state_t          state;
    logic [MS_CNT_W-1:0] ms_cnt;
    logic                bmc_q;
    logic                fp_q;
    logic                bmc_pend;
    logic                fp_pend;
    logic                fault_pend;
    logic                s3_start;
    logic                leave;

    logic bmc_fall;
    logic fp_fall;
    logic on_mismatch;
    logic fault_req;
    logic bmc_req;
    logic press_done;
    logic wait_expired;
    logic ovr_done;
    logic cool_done;
    logic s3_moved;
    logic s34_low;

    assign bmc_fall     = bmc_q & ~iBmcPwrBtn_n;
    assign fp_fall      = fp_q & ~iFpPwrBtn_n;
    // BMC wants the host on but the PCH is still in S3 or deeper.
    assign on_mismatch  = ~FM_BMC_ONCTL_N_LATCH & ~FM_SLPS3_N;
    assign fault_req    = iForceOff | fault_pend;
    assign bmc_req      = bmc_pend | on_mismatch;
    assign press_done   = i1mSCE && (ms_cnt == PULSE_LAST);
    assign wait_expired = i1mSCE && (ms_cnt == TIMEOUT_LAST);
    assign ovr_done     = i1mSCE && (ms_cnt == OVERRIDE_LAST);
    assign cool_done    = i1mSCE && (ms_cnt == COOLDOWN_LAST);
    assign s3_moved     = FM_SLPS3_N != s3_start;
    assign s34_low      = ~FM_SLPS3_N & ~FM_SLPS4_N;

    // Any state change restarts the ms count; this mirrors the transition
    // conditions used in the state register below.
    always_comb begin
        leave = 1'b0;
        case (state)
            ST_IDLE:     leave = fault_req | bmc_req | fp_pend;
            ST_PRESS:    leave = iForceOff | press_done;
            ST_WAIT_S3:  leave = iForceOff | s3_moved | wait_expired;
            ST_OVERRIDE: leave = s34_low | ovr_done;
            ST_COOLDOWN: leave = cool_done;
            default:     leave = 1'b1;
        endcase
    end

    ms_timer u_ms_timer (
        .clk   (iClk_2M),
        .rst_n (iRst_n),
        .clear (leave),
        .tick  (i1mSCE),
        .count (ms_cnt)
    );

    always_ff @(posedge iClk_2M) begin
        if (!iRst_n) begin
            state        <= ST_IDLE;
            oGrant       <= GRANT_NONE;
            oPchPwrBtn_n <= 1'b1;
            oBusy        <= 1'b0;
            oTimeout     <= 1'b0;
            bmc_q        <= 1'b1;
            fp_q         <= 1'b1;
            bmc_pend     <= 1'b0;
            fp_pend      <= 1'b0;
            fault_pend   <= 1'b0;
            s3_start     <= 1'b1;
        end else begin
            bmc_q <= iBmcPwrBtn_n;
            fp_q  <= iFpPwrBtn_n;

            case (state)
                ST_IDLE: begin
                    if (fault_req) begin
                        state        <= ST_OVERRIDE;
                        oGrant       <= GRANT_FAULT;
                        fault_pend   <= 1'b0;
                        oPchPwrBtn_n <= 1'b0;
                        oBusy        <= 1'b1;
                    end else if (bmc_req) begin
                        // Host already on and button still held: treat as a
                        // long press and go straight to the forced-off hold.
                        state        <= (FM_SLPS3_N && !iBmcPwrBtn_n) ?
                                        ST_OVERRIDE : ST_PRESS;
                        oGrant       <= GRANT_BMC;
                        bmc_pend     <= 1'b0;
                        oTimeout     <= 1'b0;
                        oPchPwrBtn_n <= 1'b0;
                        oBusy        <= 1'b1;
                    end else if (fp_pend) begin
                        state        <= (FM_SLPS3_N && !iFpPwrBtn_n) ?
                                        ST_OVERRIDE : ST_PRESS;
                        oGrant       <= GRANT_FP;
                        fp_pend      <= 1'b0;
                        oPchPwrBtn_n <= 1'b0;
                        oBusy        <= 1'b1;
                    end
                end
                ST_PRESS: begin
                    if (iForceOff) begin
                        state  <= ST_OVERRIDE;
                        oGrant <= GRANT_FAULT;
                    end else if (press_done) begin
                        state        <= ST_WAIT_S3;
                        oPchPwrBtn_n <= 1'b1;
                        s3_start     <= FM_SLPS3_N;
                    end
                end
                ST_WAIT_S3: begin
                    if (iForceOff) begin
                        state        <= ST_OVERRIDE;
                        oGrant       <= GRANT_FAULT;
                        oPchPwrBtn_n <= 1'b0;
                    end else if (s3_moved) begin
                        state <= ST_COOLDOWN;
                    end else if (wait_expired) begin
                        state    <= ST_COOLDOWN;
                        oTimeout <= 1'b1;
                    end
                end
                ST_OVERRIDE: begin
                    if (iForceOff) begin
                        fault_pend <= 1'b1;
                    end
                    if (s34_low || ovr_done) begin
                        state        <= ST_COOLDOWN;
                        oPchPwrBtn_n <= 1'b1;
                    end
                end
                ST_COOLDOWN: begin
                    if (iForceOff) begin
                        fault_pend <= 1'b1;
                    end
                    if (cool_done) begin
                        state  <= ST_IDLE;
                        oGrant <= GRANT_NONE;
                        oBusy  <= 1'b0;
                    end
                end
                default: begin
                    state        <= ST_IDLE;
                    oGrant       <= GRANT_NONE;
                    oPchPwrBtn_n <= 1'b1;
                    oBusy        <= 1'b0;
                end
            endcase

            // New edges win over a same-cycle grant clear so none are lost.
            if (bmc_fall) begin
                bmc_pend <= 1'b1;
            end
            if (fp_fall) begin
                fp_pend <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pwrbtn_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pwrbtn_seq_ctrl
// Purpose  : Self-checking bench for pwrbtn_seq_ctrl: a vector table, a few
//            directed multi-cycle sequences and randomized traffic, all
//            checked against a countdown-based behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pwrbtn_seq_ctrl;

    localparam int P_PULSE = 5;
    localparam int P_OVR   = 8;
    localparam int P_TO    = 4;
    localparam int P_CD    = 3;

    localparam int M_IDLE  = 0;
    localparam int M_PRESS = 1;
    localparam int M_WAIT  = 2;
    localparam int M_OVR   = 3;
    localparam int M_COOL  = 4;

    logic       iClk_2M = 1'b0;
    logic       iRst_n;
    logic       i1mSCE;
    logic       iFpPwrBtn_n;
    logic       iBmcPwrBtn_n;
    logic       FM_BMC_ONCTL_N_LATCH;
    logic       FM_SLPS3_N;
    logic       FM_SLPS4_N;
    logic       iForceOff;
    logic       oPchPwrBtn_n;
    logic [1:0] oGrant;
    logic       oBusy;
    logic       oTimeout;

    int total = 0;
    int bad   = 0;

    // behavioural model
    int       m_ph;
    int       m_left;
    bit [1:0] m_grant;
    bit       m_to, m_pb, m_pf, m_pq, m_bprev, m_fprev, m_start;

    typedef struct {
        bit       rst_n, bmc, fp, s3, s4, tick, frc;
        bit       eb;
        bit [1:0] eg;
        bit       ey, et;
    } vec_t;
    vec_t tv[$];

    always #5 iClk_2M = ~iClk_2M;

    pwrbtn_seq_ctrl #(
        .PULSE_MS    (P_PULSE),
        .OVERRIDE_MS (P_OVR),
        .TIMEOUT_MS  (P_TO),
        .COOLDOWN_MS (P_CD)
    ) dut (
        .iClk_2M              (iClk_2M),
        .iRst_n               (iRst_n),
        .i1mSCE               (i1mSCE),
        .iFpPwrBtn_n          (iFpPwrBtn_n),
        .iBmcPwrBtn_n         (iBmcPwrBtn_n),
        .FM_BMC_ONCTL_N_LATCH (FM_BMC_ONCTL_N_LATCH),
        .FM_SLPS3_N           (FM_SLPS3_N),
        .FM_SLPS4_N           (FM_SLPS4_N),
        .iForceOff            (iForceOff),
        .oPchPwrBtn_n         (oPchPwrBtn_n),
        .oGrant               (oGrant),
        .oBusy                (oBusy),
        .oTimeout             (oTimeout)
    );

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic enter(input int p);
        m_ph   = p;
        m_left = (p == M_PRESS) ? P_PULSE : (p == M_WAIT) ? P_TO :
                 (p == M_OVR) ? P_OVR : P_CD;
    endtask

    // Advance the model by one clock using the inputs the DUT is about to see.
    task automatic model_step();
        bit fb, ff;
        if (!iRst_n) begin
            m_ph = M_IDLE; m_left = 0; m_grant = 2'd0; m_to = 0;
            m_pb = 0; m_pf = 0; m_pq = 0; m_bprev = 1; m_fprev = 1; m_start = 1;
            return;
        end
        fb = m_bprev && !iBmcPwrBtn_n;
        ff = m_fprev && !iFpPwrBtn_n;
        case (m_ph)
            M_IDLE: begin
                if (iForceOff || m_pq) begin
                    m_pq = 0; m_grant = 2'd1; enter(M_OVR);
                end else if (m_pb || (!FM_BMC_ONCTL_N_LATCH && !FM_SLPS3_N)) begin
                    m_pb = 0; m_grant = 2'd2; m_to = 0;
                    enter((FM_SLPS3_N && !iBmcPwrBtn_n) ? M_OVR : M_PRESS);
                end else if (m_pf) begin
                    m_pf = 0; m_grant = 2'd3;
                    enter((FM_SLPS3_N && !iFpPwrBtn_n) ? M_OVR : M_PRESS);
                end
            end
            M_PRESS: begin
                if (iForceOff) begin
                    m_grant = 2'd1; enter(M_OVR);
                end else if (i1mSCE) begin
                    m_left--;
                    if (m_left == 0) begin
                        m_start = FM_SLPS3_N; enter(M_WAIT);
                    end
                end
            end
            M_WAIT: begin
                if (iForceOff) begin
                    m_grant = 2'd1; enter(M_OVR);
                end else if (FM_SLPS3_N != m_start) begin
                    enter(M_COOL);
                end else if (i1mSCE) begin
                    m_left--;
                    if (m_left == 0) begin
                        m_to = 1; enter(M_COOL);
                    end
                end
            end
            M_OVR: begin
                if (iForceOff) m_pq = 1;
                if (!FM_SLPS3_N && !FM_SLPS4_N) begin
                    enter(M_COOL);
                end else if (i1mSCE) begin
                    m_left--;
                    if (m_left == 0) enter(M_COOL);
                end
            end
            default: begin
                if (iForceOff) m_pq = 1;
                if (i1mSCE) begin
                    m_left--;
                    if (m_left == 0) begin
                        m_grant = 2'd0; m_ph = M_IDLE;
                    end
                end
            end
        endcase
        if (fb) m_pb = 1;
        if (ff) m_pf = 1;
        m_bprev = iBmcPwrBtn_n;
        m_fprev = iFpPwrBtn_n;
    endtask

    // One clock with optional tick; outputs compared to the model after it.
    task automatic cyc(input bit t);
        logic [7:0] act, exp;
        i1mSCE = t;
        model_step();
        @(posedge iClk_2M);
        #1;
        i1mSCE = 1'b0;
        act = {3'b0, oPchPwrBtn_n, oGrant, oBusy, oTimeout};
        exp = {3'b0, !(m_ph == M_PRESS || m_ph == M_OVR), m_grant, m_ph != M_IDLE, m_to};
        chk("model", act, exp);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) cyc(1'b1);
    endtask

    task automatic add(input bit r, b, f, s3, s4, t, fo,
                       input bit eb, input bit [1:0] eg, input bit ey, et);
        vec_t v;
        v = '{rst_n:r, bmc:b, fp:f, s3:s3, s4:s4, tick:t, frc:fo,
              eb:eb, eg:eg, ey:ey, et:et};
        tv.push_back(v);
    endtask

    task automatic add_n(input int n, input bit s3, input bit eb,
                         input bit [1:0] eg, input bit et);
        for (int i = 0; i < n; i++) add(1, 1, 1, s3, 0, 1, 0, eb, eg, 1, et);
    endtask

    initial begin
        iRst_n = 0; i1mSCE = 0; iFpPwrBtn_n = 1; iBmcPwrBtn_n = 1;
        FM_BMC_ONCTL_N_LATCH = 1; FM_SLPS3_N = 0; FM_SLPS4_N = 0; iForceOff = 0;

        // BMC press with host off: 5-tick pulse, SLPS3 rises on wait tick 3
        add(0,1,1,0,0,0,0, 1,2'd0,0,0);
        add(1,1,1,0,0,0,0, 1,2'd0,0,0);
        add(1,0,1,0,0,0,0, 1,2'd0,0,0);
        add(1,0,1,0,0,0,0, 0,2'd2,1,0);
        add_n(4, 0, 0, 2'd2, 0);
        add_n(1, 0, 1, 2'd2, 0);
        add_n(2, 0, 1, 2'd2, 0);
        add_n(1, 1, 1, 2'd2, 0);
        add_n(2, 1, 1, 2'd2, 0);
        add(1,1,1,1,0,1,0, 1,2'd0,0,0);
        // no SLPS3 change: timeout after 4 wait ticks
        add(1,0,1,1,0,0,0, 1,2'd0,0,0);
        add(1,1,1,1,0,0,0, 0,2'd2,1,0);
        add_n(4, 1, 0, 2'd2, 0);
        add_n(1, 1, 1, 2'd2, 0);
        add_n(3, 1, 1, 2'd2, 0);
        add_n(1, 1, 1, 2'd2, 1);
        add_n(2, 1, 1, 2'd2, 1);
        add(1,1,1,1,0,1,0, 1,2'd0,0,1);
        // next BMC grant clears the timeout flag
        add(1,0,1,1,0,0,0, 1,2'd0,0,1);
        add(1,1,1,1,0,0,0, 0,2'd2,1,0);
        add_n(4, 1, 0, 2'd2, 0);
        add_n(1, 1, 1, 2'd2, 0);
        add(1,1,1,0,0,0,0, 1,2'd2,1,0);
        add(1,1,1,0,0,1,0, 1,2'd2,1,0);
        add(1,1,1,0,0,1,0, 1,2'd2,1,0);
        add(1,1,1,0,0,1,0, 1,2'd0,0,0);

        foreach (tv[i]) begin
            iRst_n = tv[i].rst_n; iBmcPwrBtn_n = tv[i].bmc; iFpPwrBtn_n = tv[i].fp;
            FM_SLPS3_N = tv[i].s3; FM_SLPS4_N = tv[i].s4; iForceOff = tv[i].frc;
            cyc(tv[i].tick);
            chk($sformatf("vec%0d", i),
                {3'b0, oPchPwrBtn_n, oGrant, oBusy, oTimeout},
                {3'b0, tv[i].eb, tv[i].eg, tv[i].ey, tv[i].et});
        end

        // Front panel held with host on: override, SLPS3/4 drop on tick 6
        FM_SLPS3_N = 1; FM_SLPS4_N = 1; iFpPwrBtn_n = 0;
        cyc(0);
        cyc(0);
        chk("ovr_grant", {6'b0, oGrant}, 8'd3);
        chk("ovr_low", {7'b0, oPchPwrBtn_n}, 8'd0);
        ticks(5);
        chk("ovr_tick5_low", {7'b0, oPchPwrBtn_n}, 8'd0);
        FM_SLPS3_N = 0; FM_SLPS4_N = 0;
        cyc(1);
        chk("ovr_s34_release", {6'b0, oPchPwrBtn_n, oBusy}, 8'b11);
        iFpPwrBtn_n = 1;
        ticks(P_CD);
        chk("ovr_cool_idle", {7'b0, oBusy}, 8'd0);

        // Override running the full 8 ticks
        FM_SLPS3_N = 1; FM_SLPS4_N = 1; iFpPwrBtn_n = 0;
        cyc(0);
        cyc(0);
        ticks(P_OVR - 1);
        chk("ovr_tick7_low", {7'b0, oPchPwrBtn_n}, 8'd0);
        cyc(1);
        chk("ovr_tick8_release", {7'b0, oPchPwrBtn_n}, 8'd1);
        iFpPwrBtn_n = 1;
        ticks(P_CD);

        // Simultaneous BMC and front-panel edges: BMC first, panel after
        FM_SLPS3_N = 0; FM_SLPS4_N = 0;
        iBmcPwrBtn_n = 0; iFpPwrBtn_n = 0;
        cyc(0);
        iBmcPwrBtn_n = 1; iFpPwrBtn_n = 1;
        cyc(0);
        chk("both_bmc_first", {6'b0, oGrant}, 8'd2);
        ticks(P_PULSE);
        FM_SLPS3_N = 1;
        cyc(0);
        ticks(P_CD);
        chk("both_idle_between", {6'b0, oGrant}, 8'd0);
        cyc(0);
        chk("both_fp_second", {6'b0, oGrant}, 8'd3);
        ticks(P_PULSE);
        FM_SLPS3_N = 0;
        cyc(0);
        ticks(P_CD);

        // Fault mid-press, then reset while in override
        iBmcPwrBtn_n = 0;
        cyc(0);
        iBmcPwrBtn_n = 1;
        cyc(0);
        ticks(2);
        iForceOff = 1;
        cyc(0);
        chk("abort_grant", {6'b0, oGrant}, 8'd1);
        chk("abort_low_busy", {6'b0, oPchPwrBtn_n, oBusy}, 8'b01);
        iForceOff = 0;
        cyc(1);
        iRst_n = 0;
        cyc(0);
        chk("rst_release", {5'b0, oPchPwrBtn_n, oBusy, oTimeout}, 8'b100);
        chk("rst_grant", {6'b0, oGrant}, 8'd0);
        iRst_n = 1;
        cyc(0);

        // Randomized traffic against the model
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(11, 0) == 0) iBmcPwrBtn_n = ~iBmcPwrBtn_n;
            if ($urandom_range(11, 0) == 0) iFpPwrBtn_n = ~iFpPwrBtn_n;
            if ($urandom_range(24, 0) == 0) FM_SLPS3_N = ~FM_SLPS3_N;
            if ($urandom_range(24, 0) == 0) FM_SLPS4_N = ~FM_SLPS4_N;
            if ($urandom_range(39, 0) == 0) FM_BMC_ONCTL_N_LATCH = ~FM_BMC_ONCTL_N_LATCH;
            iForceOff = ($urandom_range(149, 0) == 0);
            iRst_n    = ($urandom_range(1499, 0) != 0);
            cyc($urandom_range(2, 0) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
